// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the four-initiator memory responder.
// Holds the FSM state encoding, port count, port index type and round-robin pick.
package mem_responder_pkg;

    localparam int NPORTS = 4;

    typedef logic [1:0] port_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // Rotate the request vector so the pointer sits at bit 0, then take the lowest set bit.
    function automatic port_idx_t rr_pick(input logic [NPORTS-1:0] req, input port_idx_t ptr);
        logic [2*NPORTS-1:0] dbl_s;
        port_idx_t           off_s;
        dbl_s = {req, req} >> ptr;
        off_s = 2'd0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            off_s = dbl_s[i] ? port_idx_t'(i) : off_s;
        end
        return ptr + off_s;
    endfunction

endpackage

// File: rtl/mem_responder_arb.sv
// Four-way round-robin arbiter: combinational pick plus the rotating search pointer.
// The pointer only advances when the parent accepts the grant.
module rr_arbiter4
    import mem_responder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_l,
    input  logic [NPORTS-1:0] req_i,
    input  logic              take_i,
    output logic              valid_o,
    output port_idx_t         gnt_o
);

    port_idx_t ptr_q;
    port_idx_t ptr_d;

    assign valid_o = |req_i;
    assign gnt_o   = rr_pick(req_i, ptr_q);

    // Next pointer: one past the port just granted.
    always_comb begin
        ptr_d = ptr_q;
        if (take_i && valid_o) begin
            ptr_d = gnt_o + 2'd1;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Single-ported word memory shared by four initiators, served one transaction at a time.
// Reads traverse a READ_LAT-deep pipeline; out-of-range accesses complete but touch nothing.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH    = 1024,
    parameter int ADDR_W   = 32,
    parameter int READ_LAT = 2
) (
    input  logic                          clk,
    input  logic                          rst_l,
    input  logic [NPORTS-1:0]             req,
    input  logic [NPORTS-1:0]             we,
    input  logic [NPORTS-1:0][ADDR_W-1:0] addr,
    input  logic [NPORTS-1:0][31:0]       wdata,
    output logic [NPORTS-1:0][31:0]       rdata,
    output logic [NPORTS-1:0]             done,
    output logic                          busy,
    output logic                          oob_err
);

    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                PIPE_N    = (READ_LAT > 1) ? READ_LAT - 1 : 1;
    localparam logic [2:0]        WAIT_LAST = (READ_LAT > 1) ? 3'(READ_LAT - 2) : 3'd0;
    localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);

    state_e                    state_q, state_d;
    logic [2:0]                cnt_q, cnt_d;
    port_idx_t                 gnt_q, gnt_d;
    logic                      we_q, we_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic [31:0]               wdata_q, wdata_d;
    logic [NPORTS-1:0][31:0]   rdata_q, rdata_d;
    logic [NPORTS-1:0]         done_q, done_d;
    logic                      busy_q, busy_d;
    logic                      oob_q, oob_d;
    logic [31:0]               mem_q [DEPTH];
    logic [31:0]               pipe_q [PIPE_N];

    logic                      gnt_valid_s;
    port_idx_t                 gnt_idx_s;
    logic                      take_s;
    logic                      oob_s;
    logic [IDX_W-1:0]          idx_s;
    logic [31:0]               rd_word_s;
    logic [31:0]               resp_word_s;

    rr_arbiter4 u_arb (
        .clk     (clk),
        .rst_l   (rst_l),
        .req_i   (req),
        .take_i  (take_s),
        .valid_o (gnt_valid_s),
        .gnt_o   (gnt_idx_s)
    );

    // High address bits only matter for the range check, never for indexing.
    assign oob_s       = ({1'b0, addr_q} >= DEPTH_W);
    assign idx_s       = addr_q[IDX_W-1:0];
    assign rd_word_s   = (we_q || oob_s) ? 32'h0 : mem_q[idx_s];
    assign resp_word_s = (state_q == ST_ACCESS) ? rd_word_s : pipe_q[PIPE_N-1];

    assign rdata   = rdata_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign oob_err = oob_q;

    // Transaction sequencing, request capture and output next-state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        take_s  = 1'b0;
        gnt_d   = gnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid_s) begin
                    take_s  = 1'b1;
                    gnt_d   = gnt_idx_s;
                    we_d    = we[gnt_idx_s];
                    addr_d  = addr[gnt_idx_s];
                    wdata_d = wdata[gnt_idx_s];
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (!we_q && (READ_LAT > 1)) begin
                    cnt_d   = 3'd0;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = 3'd0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = cnt_q + 3'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if ((state_d == ST_RESP) && (state_q != ST_RESP)) begin
            rdata_d[gnt_q] = resp_word_s;
        end else begin
            rdata_d = rdata_q;
        end
        done_d = (state_d == ST_RESP) ? (4'b0001 << gnt_d) : 4'b0000;
        busy_d = (state_d != ST_IDLE);
        oob_d  = oob_q | ((state_q == ST_ACCESS) && oob_s);
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            gnt_q   <= 2'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= '0;
            done_q  <= 4'b0000;
            busy_q  <= 1'b0;
            oob_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            oob_q   <= oob_d;
        end
    end

    // Read data pipeline; the output register supplies the final stage.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < PIPE_N; i++) begin
                pipe_q[i] <= 32'h0;
            end
        end else begin
            pipe_q[0] <= rd_word_s;
            for (int i = 1; i < PIPE_N; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Backing array keeps its contents across reset.
    always_ff @(posedge clk) begin
        if ((state_q == ST_ACCESS) && we_q && !oob_s) begin
            mem_q[idx_s] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Drives three mem_responder instances (READ_LAT 2, 1, 4) with shared directed stimulus,
// checks each against a transaction-level model every cycle, plus literal expectations.
module tb_mem_responder;

    localparam int DEPTH = 64;
    localparam int NDUT  = 3;

    logic              clk = 1'b0;
    logic              rst_l;
    logic [3:0]        req, we;
    logic [3:0][31:0]  addr, wdata;
    logic [3:0][31:0]  rdata_a [NDUT];
    logic [3:0]        done_a  [NDUT];
    logic              busy_a  [NDUT];
    logic              oob_a   [NDUT];

    int n_tests = 0;
    int n_fail  = 0;

    // Model state per instance: position inside the current transaction (0 = idle cycle).
    int          pos_m [NDUT];
    int          len_m [NDUT];
    int          k_m   [NDUT];
    int          ptr_m [NDUT];
    bit          txoob_m [NDUT];
    bit          oob_m [NDUT];
    logic [31:0] val_m [NDUT];
    logic [31:0] erd_m [NDUT][4];
    logic [31:0] mem_m [NDUT][DEPTH];

    int          lat_r [NDUT];
    logic [31:0] rd_r;
    int          got_ord [5];
    int          exp_ord [5] = '{0, 1, 2, 3, 0};
    int          cyc, n, prev, first_p;
    bit          prevdone;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mem_responder #(
            .DEPTH    (DEPTH),
            .ADDR_W   (32),
            .READ_LAT (g == 0 ? 2 : (g == 1 ? 1 : 4))
        ) u_dut (
            .clk     (clk),
            .rst_l   (rst_l),
            .req     (req),
            .we      (we),
            .addr    (addr),
            .wdata   (wdata),
            .rdata   (rdata_a[g]),
            .done    (done_a[g]),
            .busy    (busy_a[g]),
            .oob_err (oob_a[g])
        );
    end

    function automatic int rl_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_cycle(input int d);
        logic [3:0] edone;
        int         kk;
        bit         found;
        bit         inr;
        bit         in_flight;
        if (!rst_l) begin
            pos_m[d] = 0;
            ptr_m[d] = 0;
            oob_m[d] = 1'b0;
            for (int p = 0; p < 4; p++) erd_m[d][p] = 32'h0;
            chk($sformatf("d%0d_rst_done", d), 32'(done_a[d]), 32'h0);
            chk($sformatf("d%0d_rst_busy", d), 32'(busy_a[d]), 32'h0);
            chk($sformatf("d%0d_rst_oob", d), 32'(oob_a[d]), 32'h0);
            for (int p = 0; p < 4; p++)
                chk($sformatf("d%0d_rst_rdata%0d", d, p), rdata_a[d][p], 32'h0);
        end else begin
            in_flight = (pos_m[d] != 0) && (pos_m[d] != len_m[d] - 1);
            edone = (pos_m[d] != 0 && pos_m[d] == len_m[d] - 1) ? (4'b0001 << k_m[d]) : 4'b0000;
            chk($sformatf("d%0d_done", d), 32'(done_a[d]), 32'(edone));
            chk($sformatf("d%0d_busy", d), 32'(busy_a[d]), 32'(pos_m[d] != 0));
            chk($sformatf("d%0d_oob", d), 32'(oob_a[d]), 32'(oob_m[d]));
            for (int p = 0; p < 4; p++) begin
                if (!(in_flight && p == k_m[d]))
                    chk($sformatf("d%0d_rdata%0d", d, p), rdata_a[d][p], erd_m[d][p]);
            end
            if (pos_m[d] == 0) begin
                found = 1'b0;
                kk    = 0;
                for (int i = 0; i < 4; i++) begin
                    if (!found && req[(ptr_m[d] + i) % 4]) begin
                        kk    = (ptr_m[d] + i) % 4;
                        found = 1'b1;
                    end
                end
                if (found) begin
                    ptr_m[d]   = (kk + 1) % 4;
                    k_m[d]     = kk;
                    inr        = (addr[kk] < DEPTH);
                    txoob_m[d] = !inr;
                    if (we[kk]) begin
                        if (inr) mem_m[d][int'(addr[kk])] = wdata[kk];
                        val_m[d] = 32'h0;
                        len_m[d] = 3;
                    end else begin
                        val_m[d] = inr ? mem_m[d][int'(addr[kk])] : 32'h0;
                        len_m[d] = rl_of(d) + 2;
                    end
                    pos_m[d] = 1;
                end
            end else if (pos_m[d] == len_m[d] - 1) begin
                pos_m[d] = 0;
            end else begin
                if (pos_m[d] == 1 && txoob_m[d]) oob_m[d] = 1'b1;
                pos_m[d] = pos_m[d] + 1;
            end
            if (pos_m[d] != 0 && pos_m[d] == len_m[d] - 1) erd_m[d][k_m[d]] = val_m[d];
        end
    endtask

    task automatic drive(input int p, input bit w, input logic [31:0] a, input logic [31:0] dat);
        we[p]    = w;
        addr[p]  = a;
        wdata[p] = dat;
        req[p]   = 1'b1;
    endtask

    task automatic wait_idle();
        int  c;
        bit  idle;
        c = 0;
        do begin
            @(negedge clk);
            c++;
            idle = 1'b1;
            for (int d = 0; d < NDUT; d++) if (busy_a[d]) idle = 1'b0;
        end while (!idle && c < 50);
        if (!idle) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: busy after %0d cycles, required idle", c);
        end
    endtask

    // One request on port p held until every instance has pulsed done once.
    task automatic txn(input int p, input bit w, input logic [31:0] a, input logic [31:0] dat);
        int c;
        bit all;
        @(posedge clk); #1;
        drive(p, w, a, dat);
        for (int d = 0; d < NDUT; d++) lat_r[d] = 0;
        rd_r = 32'hxxxx_xxxx;
        c = 0;
        do begin
            @(negedge clk);
            c++;
            all = 1'b1;
            for (int d = 0; d < NDUT; d++) begin
                if (lat_r[d] == 0 && done_a[d][p]) begin
                    lat_r[d] = c;
                    if (d == 0) rd_r = rdata_a[0][p];
                end
                if (lat_r[d] == 0) all = 1'b0;
            end
        end while (!all && c < 40);
        if (!all) begin
            n_tests++;
            n_fail++;
            $display("FAIL txn_timeout: port %0d no done after %0d cycles, required done", p, c);
        end
        @(posedge clk); #1;
        req[p] = 1'b0;
        wait_idle();
    endtask

    initial begin
        rst_l = 1'b0;
        req = 4'b0000; we = 4'b0000; addr = '0; wdata = '0;
        for (int d = 0; d < NDUT; d++) begin
            pos_m[d] = 0; len_m[d] = 3; k_m[d] = 0; ptr_m[d] = 0;
            txoob_m[d] = 1'b0; oob_m[d] = 1'b0; val_m[d] = 32'h0;
            for (int p = 0; p < 4; p++) erd_m[d][p] = 32'h0;
            for (int i = 0; i < DEPTH; i++) mem_m[d][i] = 32'h0;
        end
        fork
            forever begin
                @(negedge clk);
                for (int d = 0; d < NDUT; d++) model_cycle(d);
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy_a[0]), 32'h0);
        chk("reset_done", 32'(done_a[0]), 32'h0);
        chk("reset_rdata3", rdata_a[0][3], 32'h0);

        // All four ports request from the first cycle after reset.
        rst_l = 1'b1;
        for (int p = 0; p < 4; p++) drive(p, 1'b1, 32'(10 + p), 32'hA000_0000 + 32'(p));
        for (int i = 0; i < 5; i++) got_ord[i] = -1;
        n = 0; cyc = 0;
        while (n < 5 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            for (int p = 0; p < 4; p++) begin
                if (done_a[0][p]) begin
                    if (n < 5) got_ord[n] = p;
                    n++;
                end
            end
        end
        for (int i = 0; i < 5; i++) chk($sformatf("order%0d", i), got_ord[i], exp_ord[i]);
        @(posedge clk); #1;
        req = 4'b0000;
        wait_idle();

        txn(0, 1'b1, 32'd5, 32'hDEAD_BEEF);
        chk("wr_lat_rl2", lat_r[0], 3);
        chk("wr_lat_rl1", lat_r[1], 3);
        chk("wr_lat_rl4", lat_r[2], 3);
        txn(1, 1'b0, 32'd5, 32'h0);
        chk("rd_lat_rl2", lat_r[0], 4);
        chk("rd_lat_rl1", lat_r[1], 3);
        chk("rd_lat_rl4", lat_r[2], 6);
        chk("rd_data_p1", rd_r, 32'hDEAD_BEEF);

        txn(0, 1'b1, 32'd0, 32'h1234_5678);
        txn(2, 1'b0, 32'(DEPTH + 3), 32'h0);
        chk("oob_rd_data", rd_r, 32'h0);
        chk("oob_flag", 32'(oob_a[0]), 32'h1);
        txn(3, 1'b1, 32'(DEPTH), 32'hBAD0_BAD0);
        txn(0, 1'b0, 32'd0, 32'h0);
        chk("oob_wr_dropped", rd_r, 32'h1234_5678);
        chk("oob_sticky", 32'(oob_a[0]), 32'h1);
        txn(1, 1'b0, 32'h8000_0005, 32'h0);
        chk("oob_highbit_rd", rd_r, 32'h0);

        // Reset lands in the WAIT state of the READ_LAT=2 instance.
        @(posedge clk); #1;
        drive(3, 1'b0, 32'd5, 32'h0);
        @(posedge clk);
        @(posedge clk); #2;
        rst_l = 1'b0;
        #1;
        chk("rstwait_busy", 32'(busy_a[0]), 32'h0);
        chk("rstwait_busy_rl4", 32'(busy_a[2]), 32'h0);
        chk("rstwait_done", 32'(done_a[0]), 32'h0);
        req = 4'b0000;
        @(posedge clk);
        @(posedge clk); #1;
        rst_l = 1'b1;
        chk("rst_clears_oob", 32'(oob_a[0]), 32'h0);
        txn(3, 1'b0, 32'd5, 32'h0);
        chk("after_rst_lat", lat_r[0], 4);
        chk("after_rst_data", rd_r, 32'hDEAD_BEEF);

        // One port keeps requesting: one done per transaction, idle cycle between.
        @(posedge clk); #1;
        drive(0, 1'b0, 32'd10, 32'h0);
        n = 0; cyc = 0; prev = -1; prevdone = 1'b0;
        while (n < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done_a[0][0]) begin
                chk("b2b_consec", 32'(prevdone), 32'h0);
                if (prev >= 0) chk($sformatf("b2b_gap%0d", n), cyc - prev, 4);
                chk("b2b_rdata", rdata_a[0][0], 32'hA000_0000);
                prev = cyc;
                n++;
            end
            prevdone = done_a[0][0];
        end
        if (n < 3) begin
            n_tests++;
            n_fail++;
            $display("FAIL b2b_timeout: %0d done pulses, required 3", n);
        end
        @(posedge clk); #1;
        req = 4'b0000;
        wait_idle();

        // Pointer now sits past port 0; port 2 drops before it is granted.
        @(posedge clk); #1;
        drive(1, 1'b1, 32'd20, 32'h1111_1111);
        drive(2, 1'b1, 32'd21, 32'h2222_2222);
        first_p = -1; cyc = 0;
        while (first_p < 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            for (int p = 0; p < 4; p++) if (done_a[0][p] && first_p < 0) first_p = p;
        end
        chk("rr_after_p0", first_p, 1);
        @(posedge clk); #1;
        req = 4'b0000;
        wait_idle();
        txn(2, 1'b0, 32'd20, 32'h0);
        chk("p1_write_seen", rd_r, 32'h1111_1111);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, default 1024, number of 32-bit words in the backing array.
REQ-002 Parameter ADDR_W, default 32, width of each request address.
REQ-003 Parameter READ_LAT, default 2, cycles from array access to read data valid (legal 1..4).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_l  input  1  reset; asynchronous assertion, active-low.
REQ-006 req  input  [3:0]  per-port request; ports 0..3 map to initiator handles a, b, c, d.
REQ-007 we  input  [3:0]  per-port write enable; 1 = write, 0 = read.
REQ-008 addr  input  [3:0][ADDR_W-1:0]  per-port word address.
REQ-009 wdata  input  [3:0][31:0]  per-port write data.
REQ-010 rdata  output  [3:0][31:0]  per-port read data; valid only in that port's done cycle.
REQ-011 done  output  [3:0]  per-port one-cycle completion pulse.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 oob_err  output  1  sticky flag; set on any access with addr >= DEPTH.

Function
REQ-014 Initiator protocol: initiator holds req, we, addr, wdata stable from assertion through its done cycle, then deasserts req or starts a new request the cycle after done.
REQ-015 FSM states: IDLE, ACCESS, WAIT, RESP.
REQ-016 IDLE: if req != 0, latch the granted port number, we, addr and wdata, then go to ACCESS; otherwise stay in IDLE.
REQ-017 Arbitration is round-robin: search starts at pointer ptr; the first asserted req at ptr, ptr+1, ... (mod 4) wins.
REQ-018 After each grant to port k, ptr becomes (k+1) mod 4.
REQ-019 ACCESS, write: array[addr] <= wdata this cycle; next state RESP.
REQ-020 ACCESS, read: array read issued; next state WAIT if READ_LAT > 1, otherwise RESP.
REQ-021 WAIT: counter counts READ_LAT-1 cycles, then goes to RESP.
REQ-022 RESP: done[k] = 1 for the granted port only; rdata[k] holds the read word (0 for writes); next state IDLE.
REQ-023 Latency from IDLE grant to done:
- write: 3 cycles (IDLE, ACCESS, RESP);
- read: READ_LAT + 2 cycles.
REQ-024 At most one done bit is high in any cycle; done is never high in two consecutive cycles for the same transaction.
REQ-025 rdata[j] for non-granted ports holds its last value.
REQ-026 Out of range (addr >= DEPTH):
- write is dropped and the array is unchanged;
- read returns 32'h0;
- done still pulses;
- oob_err sets and stays set until reset.
REQ-027 Simultaneous requests on all four ports are served in pointer order, one transaction at a time, with no port starved longer than 3 transactions.
REQ-028 A req that drops before its grant is simply not served; a req that drops after its grant still completes and pulses done.
REQ-029 Address bits above the index width are compared for the range check only.

Reset
REQ-030 While rst_l = 0, immediately: state = IDLE, done = 0, rdata = 0, busy = 0, oob_err = 0, ptr = 0, WAIT counter = 0.
REQ-031 Reset mid-transaction aborts it with no done pulse; a write already performed in ACCESS remains in the array.
REQ-032 Array contents are not cleared by reset.

Structure
REQ-033 A shared package holds the state enum, the port-count constant (4) and the port index typedef.
REQ-034 One sub-module, rr_arbiter4, contains the 4-way round-robin pick and the ptr register.
REQ-035 The array is a behavioural register array with a READ_LAT-deep read data pipeline.

Verification
REQ-036 Write port0 addr 5 data 32'hDEADBEEF, then read port1 addr 5 -> port1 done on cycle READ_LAT+2 with rdata[1] = 32'hDEADBEEF.
REQ-037 req = 4'b1111 asserted at the same cycle from reset -> done order 0, 1, 2, 3, then 0 again if still requesting.
REQ-038 Read port2 addr DEPTH+3 -> done[2] pulses, rdata[2] = 0, oob_err = 1 and stays 1; a following write at DEPTH leaves the array unchanged.
REQ-039 Reset pulsed during WAIT of a port3 read -> no done[3], busy = 0 immediately; after release a repeated read completes normally.
REQ-040 Sweep READ_LAT = 1 and 4 -> read done latency 3 and 6 cycles respectively; write latency 3 in both cases.
REQ-041 Back-to-back requests from one port -> each transaction yields exactly one done pulse, with at least one non-done cycle (IDLE) between pulses.
